// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared core widths and register-file types.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_if
// Description : MEM/WB write-back and decode read-port bundle of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_regfile_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);

    logic              wb_reg_wen;
    logic [ADDR_W-1:0] wb_reg_waddr;
    logic [DATA_W-1:0] wb_mem_rdata;
    logic [DATA_W-1:0] wb_alu_result;
    logic              wb_mem_to_reg;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_wdata;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output wb_reg_wen, wb_reg_waddr, wb_mem_rdata, wb_alu_result, wb_mem_to_reg,
        output rs_addr, rt_addr, dbg_addr,
        input  rs_data, rt_data, wb_wdata, dbg_data
    );

    modport slave (
        input  wb_reg_wen, wb_reg_waddr, wb_mem_rdata, wb_alu_result, wb_mem_to_reg,
        input  rs_addr, rt_addr, dbg_addr,
        output rs_data, rt_data, wb_wdata, dbg_data
    );

endinterface
`default_nettype wire

// File: rtl/regfile_bank.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bank
// Description : Register storage, async clear, one write and three raw read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_bank #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [ADDR_W-1:0] raddr_a,
    input  wire logic [ADDR_W-1:0] raddr_b,
    input  wire logic [ADDR_W-1:0] raddr_c,
    output logic      [DATA_W-1:0] rdata_a,
    output logic      [DATA_W-1:0] rdata_b,
    output logic      [DATA_W-1:0] rdata_c
);

    localparam int c_NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [c_NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata_a = r_regs[raddr_a];
    assign rdata_b = r_regs[raddr_b];
    assign rdata_c = r_regs[raddr_c];

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Write-back select, zero-register and optional same-cycle bypass
//               (WB_REGFILE_BYPASS_EN) around a 2**ADDR_W-entry register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int ZERO_REG = 1
) (
    input wire logic    clk,
    input wire logic    rst_n,
    wb_regfile_if.slave bus
);

    localparam logic c_ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] w_wdata;
    logic              w_we;
    logic [DATA_W-1:0] w_rs_raw;
    logic [DATA_W-1:0] w_rt_raw;
    logic [DATA_W-1:0] w_dbg_raw;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic [DATA_W-1:0] w_dbg_data;

    assign w_wdata = bus.wb_mem_to_reg ? bus.wb_mem_rdata : bus.wb_alu_result;

    // Dropping R0 writes keeps R0 at its cleared value, so the raw debug read is already 0.
    assign w_we = bus.wb_reg_wen && !(c_ZERO_EN && (bus.wb_reg_waddr == '0));

    regfile_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (w_we),
        .waddr   (bus.wb_reg_waddr),
        .wdata   (w_wdata),
        .raddr_a (bus.rs_addr),
        .raddr_b (bus.rt_addr),
        .raddr_c (bus.dbg_addr),
        .rdata_a (w_rs_raw),
        .rdata_b (w_rt_raw),
        .rdata_c (w_dbg_raw)
    );

    always_comb begin
        w_rs_data  = w_rs_raw;
        w_rt_data  = w_rt_raw;
        w_dbg_data = w_dbg_raw;
`ifdef WB_REGFILE_BYPASS_EN
        // Reset blocks writes, so it also blocks forwarding of the pending write.
        if (rst_n && bus.wb_reg_wen && (bus.rs_addr == bus.wb_reg_waddr)) begin
            w_rs_data = w_wdata;
        end
        if (rst_n && bus.wb_reg_wen && (bus.rt_addr == bus.wb_reg_waddr)) begin
            w_rt_data = w_wdata;
        end
`endif
        if (c_ZERO_EN && (bus.rs_addr == '0)) begin
            w_rs_data = '0;
        end
        if (c_ZERO_EN && (bus.rt_addr == '0)) begin
            w_rt_data = '0;
        end
        if (c_ZERO_EN && (bus.dbg_addr == '0)) begin
            w_dbg_data = '0;
        end
    end

    assign bus.wb_wdata = w_wdata;
    assign bus.rs_data  = w_rs_data;
    assign bus.rt_data  = w_rt_data;
    assign bus.dbg_data = w_dbg_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking bench for wb_regfile, ZERO_REG=1 and ZERO_REG=0 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;
    import cpu_pkg::*;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    logic      clk;
    logic      rst_n;
    logic      wen;
    logic      m2r;
    reg_addr_t waddr;
    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t dbg;
    word_t     rdata;
    word_t     alu;

    int checks   = 0;
    int failures = 0;

    // Reference register contents: index 0 -> ZERO_REG=1 instance, 1 -> ZERO_REG=0.
    word_t mdl [2][NUM_REGS];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wb_regfile_if bus0 ();
    wb_regfile_if bus1 ();

    assign bus0.wb_reg_wen    = wen;
    assign bus0.wb_reg_waddr  = waddr;
    assign bus0.wb_mem_rdata  = rdata;
    assign bus0.wb_alu_result = alu;
    assign bus0.wb_mem_to_reg = m2r;
    assign bus0.rs_addr       = rs;
    assign bus0.rt_addr       = rt;
    assign bus0.dbg_addr      = dbg;

    assign bus1.wb_reg_wen    = wen;
    assign bus1.wb_reg_waddr  = waddr;
    assign bus1.wb_mem_rdata  = rdata;
    assign bus1.wb_alu_result = alu;
    assign bus1.wb_mem_to_reg = m2r;
    assign bus1.rs_addr       = rs;
    assign bus1.rt_addr       = rt;
    assign bus1.dbg_addr      = dbg;

    wb_regfile #(.ZERO_REG(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    wb_regfile #(.ZERO_REG(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    function automatic word_t exp_wdata();
        return m2r ? rdata : alu;
    endfunction

    function automatic word_t exp_read(int d, reg_addr_t a, bit port_bypass);
        if (!rst_n) return '0;
        if (d == 0 && a == 0) return '0;
        if (port_bypass && c_BYPASS && wen && a == waddr) return exp_wdata();
        return mdl[d][a];
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NUM_REGS; i++) mdl[d][i] = '0;
    endtask

    task automatic commit_model();
        if (rst_n && wen) begin
            for (int d = 0; d < 2; d++)
                if (!(d == 0 && waddr == 0)) mdl[d][waddr] = exp_wdata();
        end
    endtask

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("d0.wdata", bus0.wb_wdata, exp_wdata());
        check("d0.rs",    bus0.rs_data,  exp_read(0, rs, 1'b1));
        check("d0.rt",    bus0.rt_data,  exp_read(0, rt, 1'b1));
        check("d0.dbg",   bus0.dbg_data, exp_read(0, dbg, 1'b0));
        check("d1.wdata", bus1.wb_wdata, exp_wdata());
        check("d1.rs",    bus1.rs_data,  exp_read(1, rs, 1'b1));
        check("d1.rt",    bus1.rt_data,  exp_read(1, rt, 1'b1));
        check("d1.dbg",   bus1.dbg_data, exp_read(1, dbg, 1'b0));
    endtask

    task automatic drive(input logic w, input reg_addr_t wa, input word_t rd, input word_t al,
                         input logic mr, input reg_addr_t a, input reg_addr_t b, input reg_addr_t c);
        wen = w; waddr = wa; rdata = rd; alu = al; m2r = mr;
        rs = a; rt = b; dbg = c;
        #1;
        check_all();
    endtask

    task automatic step();
        @(posedge clk);
        commit_model();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_model();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
        for (int a = 1; a < 4; a++) begin
            drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, reg_addr_t'(a), reg_addr_t'(a), reg_addr_t'(a));
            check("rst.d1.rs", bus1.rs_data, 16'h0000);
        end
        step();
        rst_n = 1'b1;

        // Preload R1..R15 with all ones
        for (int a = 1; a < 16; a++) begin
            drive(1'b1, reg_addr_t'(a), 16'hFFFF, 16'h0, 1'b1, reg_addr_t'(a), 4'd0, reg_addr_t'(a));
            step();
        end
        drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd15, 4'd1, 4'd15);
        check("preload.dbg", bus0.dbg_data, 16'hFFFF);

        // Mid-cycle reset pulse with a write in flight
        drive(1'b1, 4'd9, 16'h1111, 16'h2222, 1'b1, 4'd9, 4'd15, 4'd9);
        @(posedge clk);
        commit_model();
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        check("midrst.d0.dbg", bus0.dbg_data, 16'h0000);
        check("midrst.d1.dbg", bus1.dbg_data, 16'h0000);
        check_all();
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, reg_addr_t'(a), 16'hFFFF, 16'hFFFF, 1'b1, reg_addr_t'(a), reg_addr_t'(a), reg_addr_t'(a));
            check("rstheld.dbg", bus1.dbg_data, 16'h0000);
            step();
        end
        rst_n = 1'b1;

        // Write-back select
        drive(1'b1, 4'd5, 16'hBEEF, 16'h1234, 1'b1, 4'd5, 4'd5, 4'd5);
        check("sel.mem", bus0.wb_wdata, 16'hBEEF);
        step();
        drive(1'b1, 4'd5, 16'hBEEF, 16'h1234, 1'b0, 4'd5, 4'd5, 4'd5);
        check("sel.r5mem", bus0.dbg_data, 16'hBEEF);
        check("sel.alu", bus0.wb_wdata, 16'h1234);
        step();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd5, 4'd5, 4'd5);
        check("sel.r5alu", bus0.dbg_data, 16'h1234);

        // Zero register
        drive(1'b1, 4'd0, 16'h0, 16'hA5A5, 1'b0, 4'd0, 4'd0, 4'd0);
        step();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
        check("zero.d0.rs", bus0.rs_data, 16'h0000);
        check("zero.d1.rs", bus1.rs_data, 16'hA5A5);

        // Bypass hazard on R7
        drive(1'b1, 4'd7, 16'h0, 16'h0011, 1'b0, 4'd0, 4'd0, 4'd0);
        step();
        drive(1'b1, 4'd7, 16'h0, 16'h00C3, 1'b0, 4'd7, 4'd7, 4'd7);
        check("byp.rs", bus0.rs_data, c_BYPASS ? 16'h00C3 : 16'h0011);
        check("byp.rt", bus0.rt_data, c_BYPASS ? 16'h00C3 : 16'h0011);
        check("byp.dbg", bus0.dbg_data, 16'h0011);
        step();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd7, 4'd7, 4'd7);
        check("byp.next", bus0.rs_data, 16'h00C3);

        // Disabled write
        drive(1'b1, 4'd3, 16'h0042, 16'h0, 1'b1, 4'd0, 4'd0, 4'd0);
        step();
        drive(1'b0, 4'd3, 16'h7777, 16'h7777, 1'b1, 4'd3, 4'd3, 4'd3);
        step();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd3, 4'd3, 4'd3);
        check("nowen.r3", bus0.rs_data, 16'h0042);

        // Back-to-back writes to R2
        drive(1'b1, 4'd2, 16'h0, 16'h0001, 1'b0, 4'd1, 4'd1, 4'd2);
        step();
        drive(1'b1, 4'd2, 16'h0, 16'h0002, 1'b0, 4'd1, 4'd1, 4'd2);
        check("b2b.first", bus0.dbg_data, 16'h0001);
        step();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd1, 4'd1, 4'd2);
        check("b2b.second", bus0.dbg_data, 16'h0002);

        // Randomized traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                clear_model();
            end else begin
                rst_n = 1'b1;
            end
            begin
                reg_addr_t wa;
                wa = reg_addr_t'($urandom_range(0, 15));
                drive(logic'($urandom_range(0, 3) != 0), wa, word_t'($urandom), word_t'($urandom),
                      logic'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) == 1) ? wa : reg_addr_t'($urandom_range(0, 15)),
                      ($urandom_range(0, 2) == 0) ? wa : reg_addr_t'($urandom_range(0, 15)),
                      reg_addr_t'($urandom_range(0, 15)));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
